// File: rtl/lapido_data_mem_responder_pkg.sv
// rtl/lapido_data_mem_responder_pkg.sv - shared types and defaults for the lapido MEM-stage responder
package lapido_data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_RESP = 2'd2
  } mem_state_e;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam int MEM_CNT_WIDTH  = 4;

  // Wait-state counts above 15 do not fit the counter; clamp rather than wrap.
  function automatic logic [MEM_CNT_WIDTH-1:0] wait_count(input int wait_states);
    if (wait_states > 15) return 4'd15;
    if (wait_states < 0)  return 4'd0;
    return MEM_CNT_WIDTH'(wait_states);
  endfunction

endpackage

// File: rtl/lapido_data_ram.sv
// rtl/lapido_data_ram.sv - 1W/1R synchronous word RAM with read enable, contents never reset
module lapido_data_ram
  import lapido_data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // rdata only moves on a read so the responder can hold it outside RESP.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lapido_data_mem_responder.sv
// rtl/lapido_data_mem_responder.sv - one-at-a-time load/store responder with wait states,
// abort of pending loads and a stall output for the lapido hazard path
module lapido_data_mem_responder
  import lapido_data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  abort,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_stall
);

  localparam logic [MEM_CNT_WIDTH-1:0] WAIT_CNT = wait_count(WAIT_STATES);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  mem_state_e               state_q;
  logic [MEM_CNT_WIDTH-1:0] cnt_q;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     oor_q;
  logic                     resp_err_q;
  logic                     resp_zero_q;

  logic                     req_oor;
  logic                     accept;
  logic                     load_abort;
  logic                     enter_resp;
  logic                     cur_we;
  logic                     cur_oor;
  logic                     ram_we;
  logic [ADDR_WIDTH-1:0]    ram_raddr;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  assign req_oor    = |req_addr[DATA_WIDTH-1:ADDR_WIDTH];
  assign req_ready  = (state_q == MEM_ST_IDLE);
  // abort wins over a request presented in the same IDLE cycle
  assign accept     = req_valid & req_ready & ~abort;
  assign load_abort = abort & ~we_q & (state_q != MEM_ST_IDLE);

  assign enter_resp = NO_WAIT ? accept
                              : ((state_q == MEM_ST_WAIT) && (cnt_q == 4'd1) && !load_abort);

  // With no wait states the access enters RESP straight from IDLE, so use the live request.
  assign cur_we    = (state_q == MEM_ST_IDLE) ? req_we  : we_q;
  assign cur_oor   = (state_q == MEM_ST_IDLE) ? req_oor : oor_q;
  assign ram_raddr = (state_q == MEM_ST_IDLE) ? req_addr[ADDR_WIDTH-1:0] : addr_q;
  assign ram_we    = accept & req_we & ~req_oor;

  lapido_data_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(req_addr[ADDR_WIDTH-1:0]),
    .wdata(req_wdata),
    .re   (enter_resp),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MEM_ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_zero_q <= 1'b1;
    end else begin
      if (enter_resp) begin
        resp_err_q  <= cur_oor;
        resp_zero_q <= cur_we | cur_oor;
      end
      case (state_q)
        MEM_ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr[ADDR_WIDTH-1:0];
            oor_q   <= req_oor;
            cnt_q   <= WAIT_CNT;
            state_q <= NO_WAIT ? MEM_ST_RESP : MEM_ST_WAIT;
          end
        end
        MEM_ST_WAIT: begin
          if (load_abort) begin
            state_q <= MEM_ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= MEM_ST_RESP;
          end
        end
        MEM_ST_RESP: state_q <= MEM_ST_IDLE;
        default:     state_q <= MEM_ST_IDLE;
      endcase
    end
  end

  assign resp_valid = (state_q == MEM_ST_RESP) & ~load_abort;
  assign resp_rdata = resp_zero_q ? '0 : ram_rdata;
  assign resp_err   = resp_err_q;
  assign mem_stall  = ((state_q == MEM_ST_IDLE) & req_valid) | (state_q == MEM_ST_WAIT);

endmodule

// File: tb/tb_lapido_data_mem_responder.sv
// tb/tb_lapido_data_mem_responder.sv - self-checking bench for lapido_data_mem_responder
module tb_lapido_data_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, abort;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_stall;
  logic [31:0] resp_rdata;

  logic        r0_valid, r0_we, r0_abort;
  logic [31:0] r0_addr, r0_wdata;
  logic        r0_ready, r0_resp_valid, r0_err, r0_stall;
  logic [31:0] r0_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [1024];
  bit          known [1024];

  always #5 clk = ~clk;

  lapido_data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .abort(abort), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_stall(mem_stall)
  );

  lapido_data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_we(r0_we), .req_addr(r0_addr),
    .req_wdata(r0_wdata), .abort(r0_abort), .req_ready(r0_ready), .resp_valid(r0_resp_valid),
    .resp_rdata(r0_rdata), .resp_err(r0_err), .mem_stall(r0_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the responder idle.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int abort_at);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          in_rng, chk_rd, load_aborted;
    in_rng = (addr < 32'd1024);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    #3;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    chk("stall_req", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    if (we && in_rng) begin
      mem_m[addr[9:0]] = wd;
      known[addr[9:0]] = 1'b1;
    end
    exp_err = !in_rng;
    exp_rd  = 32'd0;
    chk_rd  = 1'b1;
    if (!we && in_rng) begin
      if (known[addr[9:0]]) exp_rd = mem_m[addr[9:0]];
      else chk_rd = 1'b0;
    end
    load_aborted = 1'b0;
    for (int k = 1; k <= W; k++) begin
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      if (abort_at == k) abort = 1'b1;
      #3;
      chk("wait_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("wait_stall", {31'd0, mem_stall}, 32'd1);
      chk("wait_not_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      if (abort_at == k && !we) begin
        load_aborted = 1'b1;
        break;
      end
    end
    if (load_aborted) begin
      req_valid = 1'b0;
      #3;
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("abort_no_stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (abort_at == W + 1) abort = 1'b1;
    #3;
    if (abort_at == W + 1 && !we) begin
      chk("resp_aborted", {31'd0, resp_valid}, 32'd0);
    end else begin
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      if (chk_rd) chk("resp_rdata", resp_rdata, exp_rd);
    end
    chk("resp_stall", {31'd0, mem_stall}, 32'd0);
    chk("resp_not_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; req_valid = 1'b0;
    #3;
    chk("post_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("hold_err", {31'd0, resp_err}, {31'd0, exp_err});
    if (chk_rd) chk("hold_rdata", resp_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] a;
    int          ab;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    pool[0] = 32'h10; pool[1] = 32'h0; pool[2] = 32'h3FF; pool[3] = 32'h55;
    pool[4] = 32'h100; pool[5] = 32'h2A; pool[6] = 32'h1; pool[7] = 32'h200;

    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h1111_2222; abort = 1'b0;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0; r0_abort = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd1);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_access(1'b1, 32'h20, 32'h1111_2222, 0);

    do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    do_access(1'b0, 32'h10, 32'h0, 0);
    do_access(1'b0, 32'h20, 32'h0, 0);

    do_access(1'b1, 32'h0, 32'hA5A5_0000, 0);
    do_access(1'b1, 32'h400, 32'h1, 0);
    do_access(1'b0, 32'h0, 32'h0, 0);
    do_access(1'b0, 32'h8000_0010, 32'h0, 0);

    do_access(1'b0, 32'h10, 32'h0, 1);
    do_access(1'b1, 32'h30, 32'hCAFE_F00D, 1);
    do_access(1'b0, 32'h30, 32'h0, 0);
    do_access(1'b0, 32'h10, 32'h0, W + 1);

    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0000_0BAD; abort = 1'b1;
    #3;
    chk("idle_abort_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; abort = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      #3;
      chk("idle_abort_not_taken", {30'd0, req_ready, resp_valid}, 32'd2);
      @(posedge clk); #1;
    end
    do_access(1'b0, 32'h10, 32'h0, 0);

    foreach (pool[i]) do_access(1'b1, pool[i], $urandom, 0);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
      else a = pool[$urandom_range(0, 7)];
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      do_access(1'($urandom), a, $urandom, ab);
    end

    do_access(1'b0, 32'h0, 32'h0, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_err", {31'd0, resp_err}, 32'd0);
    chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      #3;
      chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    do_access(1'b0, 32'h10, 32'h0, 0);

    for (int p = 0; p < 2; p++) begin
      r0_valid = 1'b1; r0_we = (p == 0); r0_addr = 32'h3; r0_wdata = 32'h1234_5678;
      #3;
      chk("w0_accept_stall", {30'd0, r0_stall, r0_ready}, 32'd3);
      @(posedge clk); #1;
      r0_valid = 1'b0; r0_wdata = $urandom;
      #3;
      chk("w0_resp_valid", {31'd0, r0_resp_valid}, 32'd1);
      chk("w0_resp_stall", {30'd0, r0_stall, r0_ready}, 32'd0);
      chk("w0_rdata", r0_rdata, (p == 0) ? 32'h0 : 32'h1234_5678);
      chk("w0_err", {31'd0, r0_err}, 32'd0);
      @(posedge clk); #1;
      #3;
      chk("w0_post", {29'd0, r0_resp_valid, r0_stall, r0_ready}, 32'd1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
